// File: rtl/timer_pkg.sv
// Shared types and constants for the irrigation timer controller.
//   timer_state_t : controller FSM states
//   bcd_t         : one BCD digit
//   bcd_time_t    : MM:SS count as four BCD digits (tens-min .. units-sec)
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t dm;
    bcd_t um;
    bcd_t ds;
    bcd_t us;
  } bcd_time_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX    = 4'd9;

endpackage

// File: rtl/tick_prescaler.sv
// One-second prescaler for the irrigation timer.
//   clk, rst_n : clock and synchronous active-low reset
//   en         : advance the prescaler this cycle
//   clr        : force the prescaler to 0 (wins over en)
//   tick       : combinational, high in the cycle where the prescaler wraps
module tick_prescaler #(
  parameter int unsigned TICK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rega_timer_ctrl.sv
// Irrigation timer sequencing controller: loads an MM:SS BCD preset, counts
// down once per second, drives the valve while running, supports pause/abort.
//   clk, rst_n                 : clock, synchronous active-low reset
//   start, stop, pause         : operator controls (levels)
//   preset_{us,ds,um,dm}       : BCD preset
//   cnt_{us,ds,um,dm}          : current BCD count (registered)
//   valve_on, busy             : status (registered)
//   done, aborted, preset_err  : one-cycle event pulses (registered)
module rega_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [3:0] preset_us,
  input  logic [3:0] preset_ds,
  input  logic [3:0] preset_um,
  input  logic [3:0] preset_dm,
  output logic [3:0] cnt_us,
  output logic [3:0] cnt_ds,
  output logic [3:0] cnt_um,
  output logic [3:0] cnt_dm,
  output logic       valve_on,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       preset_err
);

  timer_state_t state_q, state_d;
  bcd_time_t    count_q, count_d;
  logic         valve_on_q, valve_on_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         aborted_q, aborted_d;
  logic         preset_err_q, preset_err_d;

  logic         presc_en, presc_clr, tick;
  bcd_time_t    preset, count_dec;
  logic         preset_valid, preset_zero, count_at_one;
  logic         b_us, b_ds, b_um;

  assign preset = '{dm: preset_dm, um: preset_um, ds: preset_ds, us: preset_us};

  // The prescaler runs for the whole RUN cycle, including one where pause or
  // stop is sampled, so a coincident tick is consumed and lost.
  assign presc_en = (state_q == RUN);

  tick_prescaler #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  // Preset validation and BCD borrow chain.
  always_comb begin
    preset_valid = (preset.us <= DIGIT_MAX) && (preset.ds <= SEC_TENS_MAX) &&
                   (preset.um <= DIGIT_MAX) && (preset.dm <= DIGIT_MAX);
    preset_zero  = (preset == '0);
    count_at_one = (count_q == 16'h0001);

    b_us = (count_q.us == 4'd0);
    b_ds = b_us && (count_q.ds == 4'd0);
    b_um = b_ds && (count_q.um == 4'd0);

    count_dec.us = b_us ? DIGIT_MAX : count_q.us - 4'd1;
    count_dec.ds = !b_us ? count_q.ds : (b_ds ? SEC_TENS_MAX : count_q.ds - 4'd1);
    count_dec.um = !b_ds ? count_q.um : (b_um ? DIGIT_MAX : count_q.um - 4'd1);
    count_dec.dm = !b_um ? count_q.dm : count_q.dm - 4'd1;
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    presc_clr    = 1'b0;
    aborted_d    = 1'b0;
    preset_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (!preset_valid) begin
            preset_err_d = 1'b1;
          end else if (preset_zero) begin
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d   = preset;
            presc_clr = 1'b1;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          count_d   = '0;
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (tick) begin
          if (count_at_one) begin
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = count_dec;
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          count_d   = '0;
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered from the next state.
    valve_on_d = (state_d == RUN) || (state_d == PAUSE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      valve_on_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      preset_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      valve_on_q   <= valve_on_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      preset_err_q <= preset_err_d;
    end
  end

  assign cnt_us     = count_q.us;
  assign cnt_ds     = count_q.ds;
  assign cnt_um     = count_q.um;
  assign cnt_dm     = count_q.dm;
  assign valve_on   = valve_on_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign preset_err = preset_err_q;

endmodule

// File: tb/tb_rega_timer_ctrl.sv
// Self-checking bench for rega_timer_ctrl with a 4-cycle tick.
module tb_rega_timer_ctrl;

  localparam int unsigned TC = 4;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, pause;
  logic [3:0] preset_us, preset_ds, preset_um, preset_dm;
  logic [3:0] cnt_us, cnt_ds, cnt_um, cnt_dm;
  logic       valve_on, busy, done, aborted, preset_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    logic [15:0] preset;
    logic        err;
    int unsigned secs;
    logic [15:0] first_tick;
  } vec_t;

  typedef struct {
    logic        err;
    int          done_k;
    int unsigned valve_cycles;
    logic [15:0] first_tick;
    logic        chk_first;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  rega_timer_ctrl #(.TICK_CYCLES(TC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .preset_us(preset_us), .preset_ds(preset_ds),
    .preset_um(preset_um), .preset_dm(preset_dm),
    .cnt_us(cnt_us), .cnt_ds(cnt_ds), .cnt_um(cnt_um), .cnt_dm(cnt_dm),
    .valve_on(valve_on), .busy(busy), .done(done),
    .aborted(aborted), .preset_err(preset_err)
  );

  function automatic logic [15:0] cnt_all();
    return {cnt_dm, cnt_um, cnt_ds, cnt_us};
  endfunction

  function automatic logic [4:0] flags();
    return {valve_on, busy, done, aborted, preset_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_preset(input logic [15:0] p);
    {preset_dm, preset_um, preset_ds, preset_us} = p;
  endtask

  // Drive one start, push the expectation, then follow the cycle to its end.
  task automatic run_vec(input vec_t v, input string nm);
    exp_t e;
    int   done_k, bound;
    int unsigned valve_cnt;
    logic [15:0] first;
    logic        got_err;

    e.err          = v.err;
    e.done_k       = v.err ? -1 : int'(v.secs * TC);
    e.valve_cycles = v.err ? 0 : v.secs * TC;
    e.first_tick   = v.first_tick;
    e.chk_first    = !v.err && (v.secs != 0);
    set_preset(v.preset);
    start = 1'b1;
    exp_q.push_back(e);
    step();
    start = 1'b0;

    got_err   = preset_err;
    if (!v.err && v.secs != 0) check({nm, " load"}, cnt_all(), v.preset);
    done_k    = -1;
    valve_cnt = 0;
    first     = 16'hxxxx;
    bound     = int'(v.secs * TC) + 8;
    for (int k = 0; k <= bound; k++) begin
      if (valve_on) valve_cnt++;
      if (k == int'(TC)) first = cnt_all();
      if (int'(done) + int'(aborted) + int'(preset_err) > 1)
        check({nm, " pulse_overlap"}, {done, aborted, preset_err}, 3'b000);
      if (done) begin
        done_k = k;
        break;
      end
      if (!busy) break;
      step();
    end

    if (exp_q.size() == 0) begin
      check({nm, " scoreboard_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({nm, " err"}, got_err, e.err);
      check({nm, " done_cycle"}, done_k, e.done_k);
      check({nm, " valve_cycles"}, valve_cnt, e.valve_cycles);
      if (e.chk_first) check({nm, " first_tick"}, first, e.first_tick);
    end

    if (done_k >= 0) begin
      check({nm, " count_at_done"}, cnt_all(), 16'h0000);
      step();
      check({nm, " after_done"}, flags(), 5'b00000);
    end else begin
      check({nm, " idle_after_err"}, {valve_on, busy}, 2'b00);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   dk;

    vecs[0] = '{16'h0003, 1'b0, 3,   16'h0002};
    vecs[1] = '{16'h1000, 1'b0, 600, 16'h0959};
    vecs[2] = '{16'h0100, 1'b0, 60,  16'h0059};
    vecs[3] = '{16'h0010, 1'b0, 10,  16'h0009};
    vecs[4] = '{16'h0110, 1'b0, 70,  16'h0109};
    vecs[5] = '{16'h0060, 1'b1, 0,   16'h0000};
    vecs[6] = '{16'h000A, 1'b1, 0,   16'h0000};
    vecs[7] = '{16'hA000, 1'b1, 0,   16'h0000};
    vecs[8] = '{16'h0000, 1'b0, 0,   16'h0000};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    set_preset(16'h0000);
    step();
    step();
    check("reset_flags", flags(), 5'b00000);
    check("reset_count", cnt_all(), 16'h0000);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Pause for 10 cycles from RUN cycle 2: done moves from edge 8 to 18.
    set_preset(16'h0002); start = 1'b1; step(); start = 1'b0;
    set_preset(16'h0959);
    step();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("pause_freeze", cnt_all(), 16'h0002);
      check("pause_valve", {valve_on, busy}, 2'b11);
    end
    pause = 1'b0;
    dk = -1;
    for (int k = 12; k <= 30; k++) begin
      step();
      if (done) begin
        dk = k;
        break;
      end
    end
    check("pause_done_cycle", dk, 18);
    step();
    check("pause_busy_fall", busy, 1'b0);

    // Abort with the count at 00:05.
    set_preset(16'h0005); start = 1'b1; step(); start = 1'b0;
    step();
    stop = 1'b1; step(); stop = 1'b0;
    check("abort_flags", flags(), 5'b00010);
    check("abort_count", cnt_all(), 16'h0000);
    step();
    check("abort_pulse_end", aborted, 1'b0);

    // Pause coinciding with the first tick: that second is lost.
    set_preset(16'h0005); start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    pause = 1'b1; step(); pause = 1'b0;
    check("pause_tick_discard", cnt_all(), 16'h0005);
    for (int i = 0; i < 4; i++) begin
      step();
      check("pause_tick_hold", cnt_all(), 16'h0005);
    end
    step();
    check("pause_tick_resume", cnt_all(), 16'h0004);
    stop = 1'b1; step(); stop = 1'b0;
    check("pause_tick_abort", aborted, 1'b1);
    step();

    // Stop coinciding with a tick.
    set_preset(16'h0005); start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    stop = 1'b1; step(); stop = 1'b0;
    check("stop_tick_flags", flags(), 5'b00010);
    check("stop_tick_count", cnt_all(), 16'h0000);
    step();

    // Reset mid-run.
    set_preset(16'h0003); start = 1'b1; step(); start = 1'b0;
    step();
    rst_n = 1'b0; step();
    check("midrst_flags", flags(), 5'b00000);
    check("midrst_count", cnt_all(), 16'h0000);
    rst_n = 1'b1; step();
    check("midrst_release", flags(), 5'b00000);

    // Start held across DONE -> IDLE re-enters RUN on the first IDLE cycle.
    set_preset(16'h0001); start = 1'b1; step();
    check("hold_run", valve_on, 1'b1);
    for (int i = 0; i < 3; i++) step();
    step();
    check("hold_done", {done, valve_on}, 2'b10);
    step();
    check("hold_idle", {valve_on, busy}, 2'b00);
    step();
    check("hold_rerun", {valve_on, busy}, 2'b11);
    check("hold_rerun_count", cnt_all(), 16'h0001);
    start = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
